// File: rtl/io_uart_if.sv
// CPU I/O bus window of the serial port: decoded select, word address, strobes and data.
interface io_uart_if;
  logic        sel;
  logic        addr;
  logic        wr;
  logic        rd;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output sel, addr, wr, rd, din, input dout);
  modport slave  (input sel, addr, wr, rd, din, output dout);
endinterface

// File: rtl/io_uart_fifo.sv
// FIFO-buffered 8N1 UART for the RISC5 I/O space with programmable divisor and sticky error flags.
// Optional interrupt logic is built when UART_IRQ_EN is defined.
module io_uart_fifo #(
  parameter int DEPTH    = 16,
  parameter int DIV_FAST = 216,
  parameter int DIV_SLOW = 1301
) (
  input  logic     clk,
  input  logic     rst,
  io_uart_if.slave bus,
  input  logic     rxd,
  output logic     txd,
  output logic     irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0]   DIV_F = 16'(DIV_FAST);
  localparam logic [15:0]   DIV_S = 16'(DIV_SLOW);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  logic [15:0] div;
  logic        ovr, ferr;
  logic [1:0]  ie_bits;
  logic [31:0] status;

  logic cpu_wr_data, cpu_wr_ctl, cpu_rd_data, clr;
  assign cpu_wr_data = bus.sel & bus.wr & ~bus.addr;
  assign cpu_wr_ctl  = bus.sel & bus.wr &  bus.addr;
  assign cpu_rd_data = bus.sel & bus.rd & ~bus.addr;
  assign clr         = cpu_wr_ctl & bus.din[30];

  logic din_unused;
  assign din_unused = ^{bus.din[29:16], bus.din[2:1]};

  // ---------------- TX FIFO + FSM ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_push, tx_pop, tx_end;
  st_t           tx_st;
  logic [15:0]   tx_div, tx_tmr;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;

  assign tx_end  = (tx_tmr == 16'd0);
  // Starting straight out of the stop bit keeps back-to-back frames gapless.
  assign tx_pop  = (tx_cnt != '0) & ((tx_st == IDLE) | ((tx_st == STOP) & tx_end));
  assign tx_push = cpu_wr_data & ((tx_cnt != FULL) | tx_pop);

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp] <= bus.din[7:0];

  always_ff @(posedge clk)
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end

  always_ff @(posedge clk)
    if (!rst) begin
      tx_st  <= IDLE;
      txd    <= 1'b1;
      tx_div <= '0;
      tx_tmr <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else if (tx_pop) begin
      tx_st  <= START;
      txd    <= 1'b0;
      tx_div <= div;
      tx_tmr <= div;
      tx_sh  <= tx_mem[tx_rp];
    end else if (tx_st != IDLE) begin
      if (!tx_end) tx_tmr <= tx_tmr - 16'd1;
      else begin
        tx_tmr <= tx_div;
        case (tx_st)
          START: begin
            tx_st  <= DATA;
            tx_bit <= '0;
            txd    <= tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[7:1]};
          end
          DATA:
            if (tx_bit == 3'd7) begin
              tx_st <= STOP;
              txd   <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              txd    <= tx_sh[0];
              tx_sh  <= {1'b0, tx_sh[7:1]};
            end
          default: begin
            tx_st <= IDLE;
            txd   <= 1'b1;
          end
        endcase
      end
    end

  // ---------------- RX FSM + FIFO ----------------
  logic          rx_s1, rx_s2, rx_prev;
  st_t           rx_st;
  logic [15:0]   rx_div, rx_tmr;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_smp, rx_done, rx_fe;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_push, rx_pop;

  assign rx_smp  = (rx_st != IDLE) & (rx_tmr == 16'd0);
  assign rx_done = rx_smp & (rx_st == STOP) &  rx_s2;
  assign rx_fe   = rx_smp & (rx_st == STOP) & ~rx_s2;
  assign rx_pop  = cpu_rd_data & (rx_cnt != '0);
  assign rx_push = rx_done & ((rx_cnt != FULL) | rx_pop);

  always_ff @(posedge clk)
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_div  <= '0;
      rx_tmr  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (rx_st == IDLE) begin
        if (rx_prev & ~rx_s2) begin
          rx_st  <= START;
          rx_div <= div;
          rx_tmr <= div >> 1;  // first sample lands mid start bit
        end
      end else if (rx_tmr != 16'd0) begin
        rx_tmr <= rx_tmr - 16'd1;
      end else begin
        rx_tmr <= rx_div;
        if (rx_st == START) begin
          if (rx_s2) rx_st <= IDLE;
          else begin
            rx_st  <= DATA;
            rx_bit <= '0;
          end
        end else if (rx_st == DATA) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= STOP;
        end else begin
          rx_st <= IDLE;
        end
      end
    end

  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wp] <= rx_sh;

  always_ff @(posedge clk)
    if (!rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end

  // ---------------- control / flags ----------------
  logic ovr_set;
  assign ovr_set = (cpu_wr_data & (tx_cnt == FULL) & ~tx_pop) |
                   (rx_done & (rx_cnt == FULL) & ~rx_pop);

  always_ff @(posedge clk)
    if (!rst) begin
      div  <= DIV_S;
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (cpu_wr_ctl)
        div <= bus.din[31] ? bus.din[15:0] : (bus.din[0] ? DIV_F : DIV_S);
      if (clr) begin
        ovr  <= 1'b0;
        ferr <= 1'b0;
      end else begin
        ovr  <= ovr | ovr_set;
        ferr <= ferr | rx_fe;
      end
    end

`ifdef UART_IRQ_EN
  logic ie_rx, ie_tx;
  always_ff @(posedge clk)
    if (!rst) begin
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (cpu_wr_ctl & ~bus.din[31]) begin
        ie_rx <= bus.din[1];
        ie_tx <= bus.din[2];
      end
      irq <= (ie_rx & (rx_cnt != '0)) | (ie_tx & (tx_cnt == '0)) | (ie_rx & (ovr | ferr));
    end
  assign ie_bits = {ie_tx, ie_rx};
`else
  assign irq     = 1'b0;
  assign ie_bits = 2'b00;
`endif

  assign status = {8'h00, 8'(tx_cnt), 8'(rx_cnt), 1'b0, ie_bits,
                   (tx_cnt == '0) & (tx_st == IDLE), ferr, ovr,
                   tx_cnt != FULL, rx_cnt != '0};

  assign bus.dout = bus.addr ? status :
                    ((rx_cnt != '0) ? {24'h0, rx_mem[rx_rp]} : 32'h0);
endmodule

// File: tb/tb_io_uart_fifo.sv
// Randomized bench for io_uart_fifo: queue-based reference model compared every cycle,
// plus directed frames with hand-computed expectations.
module tb_io_uart_fifo;
  localparam int DEPTH    = 16;
  localparam int DIV_FAST = 216;
  localparam int DIV_SLOW = 1301;

  logic clk = 1'b0, rst = 1'b0, rxd = 1'b1;
  logic txd, irq;
  io_uart_if bus();

  io_uart_fifo #(.DEPTH(DEPTH), .DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rxd(rxd), .txd(txd), .irq(irq));

  always #5 clk = ~clk;

  int checks = 0, passed = 0, fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned div_m;
  bit          ovr_m, ferr_m, ie_rx_m, ie_tx_m, irq_m;
  byte unsigned txq[$], rxq[$];
  int          tx_rem, tx_d;
  byte unsigned tx_byte;
  bit          rx_busy = 0, cmp_on = 0;
  bit          inj = 0, inj_ok;
  byte unsigned inj_byte;

  int  pre_tx, pre_rx;
  bit  txpop, rxpop, set_o, set_f, clr_m, irq_n;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      div_m = DIV_SLOW; ovr_m = 0; ferr_m = 0; ie_rx_m = 0; ie_tx_m = 0; irq_m = 0;
      txq.delete(); rxq.delete(); tx_rem = 0; tx_d = 0; inj = 0;
    end else begin
      pre_tx = txq.size(); pre_rx = rxq.size();
      irq_n = (ie_rx_m && pre_rx > 0) || (ie_tx_m && pre_tx == 0) || (ie_rx_m && (ovr_m || ferr_m));
      txpop = (pre_tx > 0) && (tx_rem <= 1);
      rxpop = bus.sel && bus.rd && !bus.addr && (pre_rx > 0);
      set_o = 0; set_f = 0; clr_m = 0;
      if (txpop) begin
        tx_byte = txq.pop_front(); tx_d = div_m; tx_rem = 10 * (div_m + 1);
      end else if (tx_rem > 0) tx_rem--;
      if (bus.sel && bus.wr && !bus.addr) begin
        if (pre_tx < DEPTH || txpop) txq.push_back(bus.din[7:0]);
        else set_o = 1;
      end
      if (rxpop) void'(rxq.pop_front());
      if (inj) begin
        inj = 0;
        if (!inj_ok) set_f = 1;
        else if (pre_rx < DEPTH || rxpop) rxq.push_back(inj_byte);
        else set_o = 1;
      end
      if (bus.sel && bus.wr && bus.addr) begin
        if (bus.din[31]) div_m = bus.din[15:0];
        else div_m = bus.din[0] ? DIV_FAST : DIV_SLOW;
`ifdef UART_IRQ_EN
        if (!bus.din[31]) begin ie_rx_m = bus.din[1]; ie_tx_m = bus.din[2]; end
`endif
        clr_m = bus.din[30];
      end
      ovr_m  = clr_m ? 1'b0 : (ovr_m | set_o);
      ferr_m = clr_m ? 1'b0 : (ferr_m | set_f);
      irq_m  = irq_n;
    end
  end

  function automatic logic exp_txd();
    int per, el, b;
    if (tx_rem == 0) return 1'b1;
    per = tx_d + 1;
    el  = 10 * per - tx_rem;
    b   = el / per;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return tx_byte[b-1];
  endfunction

  logic [31:0] e_stat, e_mask;
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      e_stat = {8'h00, 8'(txq.size()), 8'(rxq.size()), 1'b0, 2'b00,
                (txq.size() == 0) && (tx_rem == 0), ferr_m, ovr_m,
                txq.size() != DEPTH, rxq.size() != 0};
`ifdef UART_IRQ_EN
      e_stat[5] = ie_rx_m; e_stat[6] = ie_tx_m;
`endif
      e_mask = rx_busy ? 32'h0000_FF0D : 32'h0;
      check("txd", txd, exp_txd());
      if (bus.addr) check("status", bus.dout & ~e_mask, e_stat & ~e_mask);
      else if (!rx_busy) check("rxdata", bus.dout, rxq.size() != 0 ? {24'h0, rxq[0]} : 32'h0);
      if (!rx_busy) check("irq", irq, irq_m);
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic bus_idle();
    bus.sel = 0; bus.wr = 0; bus.rd = 0; bus.addr = 0; bus.din = 0;
  endtask
  task automatic wr(bit a, logic [31:0] d);
    bus.sel = 1; bus.wr = 1; bus.rd = 0; bus.addr = a; bus.din = d;
    cyc(); bus_idle();
  endtask
  task automatic rd(bit a, output logic [31:0] v);
    bus.sel = 1; bus.rd = 1; bus.wr = 0; bus.addr = a; bus.din = 0;
    @(negedge clk); v = bus.dout;
    cyc(); bus_idle();
  endtask
  task automatic rx_frame(byte unsigned b, bit ok, int d);
    rx_busy = 1;
    for (int i = 0; i < 10; i++) begin
      rxd = (i == 0) ? 1'b0 : (i == 9) ? ok : b[i-1];
      repeat (d + 1) cyc();
    end
    rxd = 1;
    repeat (4) cyc();
    inj_byte = b; inj_ok = ok; inj = 1;
    cyc(); cyc();
    rx_busy = 0;
  endtask
  task automatic rx_glitch(int d);
    rx_busy = 1;
    rxd = 0; repeat (3) cyc(); rxd = 1;
    repeat (2 * (d + 1) + 6) cyc();
    rx_busy = 0;
  endtask

  logic [31:0] v;
  logic [9:0]  pat;
  int          cur_div, r;

  initial begin
    bus_idle();
    rst = 0; cyc(); cmp_on = 1; cyc(); rst = 1; cyc();

    rd(1, v);
    check("reset_status", v, 32'h0000_0012);
    check("reset_txd", txd, 1'b1);

    // 0xA5 at 10-clock bits
    wr(1, 32'h8000_0009);
    wr(0, 32'h0000_00A5);
    cyc();
    pat = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      repeat (5) cyc();
      check("a5_bit", txd, pat[k]);
      repeat (5) cyc();
    end
    rd(1, v);
    check("a5_done_idle", v[4], 1'b1);

    // fill TX: 17 writes, first one is popped at once
    for (int i = 0; i < 17; i++) begin
      bus.sel = 1; bus.wr = 1; bus.addr = 0; bus.din = 32'h10 + i; cyc();
    end
    bus_idle();
    rd(1, v);
    check("full_notfull", v[1], 1'b0);
    check("full_count", v[23:16], 32'd16);
    check("full_ovr0", v[2], 1'b0);
    wr(0, 32'hEE);
    rd(1, v);
    check("drop_ovr", v[2], 1'b1);
    wr(1, 32'hC000_0009);
    rd(1, v);
    check("clear_ovr", v[2], 1'b0);
    repeat (1700) cyc();

    // RX frames at divisor 9
    rx_frame(8'h3C, 1, 9);
    rx_frame(8'hC3, 1, 9);
    rd(1, v); check("rx_count2", v[15:8], 32'd2);
    rd(0, v); check("rx_3c", v, 32'h3C);
    rd(0, v); check("rx_c3", v, 32'h C3);
    rd(1, v); check("rx_empty", v[0], 1'b0);
    rx_glitch(9);
    rx_frame(8'h81, 0, 9);
    rd(1, v);
    check("ferr_set", v[3], 1'b1);
    check("ferr_nocount", v[15:8], 32'd0);
    wr(1, 32'hC000_0009);
    rx_frame(8'h5A, 1, 9);
    rd(0, v); check("rx_after_glitch", v, 32'h5A);

    // RX overflow at divisor 3
    wr(1, 32'h8000_0003);
    for (int i = 0; i < 17; i++) rx_frame(8'(8'h20 + i), 1, 3);
    rd(1, v);
    check("rxfull_count", v[15:8], 32'd16);
    check("rxfull_ovr", v[2], 1'b1);
    wr(1, 32'hC000_0003);
    for (int i = 0; i < 16; i++) begin
      rd(0, v); check("rxfull_data", v, 32'h20 + i);
    end

`ifdef UART_IRQ_EN
    wr(1, 32'h0000_0002);
    rx_frame(8'h55, 1, DIV_SLOW);
    check("irq_on", irq, 1'b1);
    rd(0, v);
    check("irq_data", v, 32'h55);
    cyc();
    check("irq_off", irq, 1'b0);
    wr(1, 32'h0000_0000);
    wr(1, 32'h8000_0003);
`endif

    // randomized traffic
    cur_div = 3;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 29);
      if (r < 10) wr(0, $urandom_range(0, 255));
      else if (r < 12) begin
        cur_div = $urandom_range(3, 9);
        wr(1, {1'b1, 1'($urandom_range(0, 1)), 14'h0, 16'(cur_div)});
      end else if (r < 16) rd(0, v);
      else if (r < 18) rd(1, v);
      else if (r < 23) repeat ($urandom_range(1, 20)) cyc();
      else if (r < 29) rx_frame(8'($urandom_range(0, 255)), $urandom_range(0, 9) != 0, cur_div);
      else begin
        rst = 0; cyc(); rst = 1;
        cur_div = $urandom_range(3, 9);
        wr(1, 32'h8000_0000 | cur_div);
      end
    end
    repeat (2000) cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
